// File: rtl/pc_unit_pkg.sv
// Shared types and helpers for the program-counter unit: command encoding,
// interrupt priority encoder and return-stack level width.
package pc_unit_pkg;

   typedef enum logic [2:0] {
      HOLD,
      INC,
      JMP,
      CALL,
      RET,
      RETI,
      INTE
   } cmd_e;

   localparam int MAX_NINT = 32;

   // Lowest set index among the first n request bits; 0 when none are set.
   function automatic int prio_index(input logic [MAX_NINT-1:0] req, input int n);
      int idx;
      idx = 0;
      for (int i = n - 1; i >= 0; i--) begin
         if (req[i[4:0]]) idx = i;
      end
      return idx;
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO. Storage updates on the falling edge; only the
// level counter is reset, so entry contents are undefined after reset.
module pc_ret_stack
   import pc_unit_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DEPTH = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  logic                       pop,
   input  logic [AW-1:0]              data_in,
   output logic [AW-1:0]              data_out,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int LW = lvl_w(DEPTH);
   localparam int IW = $clog2(DEPTH);

   logic [AW-1:0] mem [DEPTH];
   logic [LW-1:0] level_m1;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign level_m1 = level - LW'(1);
   assign wr_idx   = level[IW-1:0];
   assign rd_idx   = level_m1[IW-1:0];
   assign data_out = empty ? '0 : mem[rd_idx];

   // A push into a full stack is dropped; the caller flags the overflow.
   always_ff @(negedge CLK) begin
      if (push && !full) mem[wr_idx] <= data_in;
   end

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         level <= '0;
      end else if (push && !full) begin
         level <= level + LW'(1);
      end else if (pop && !empty) begin
         level <= level_m1;
      end
   end

endmodule

// File: rtl/pc_unit_stk.sv
// Fetch-stage program counter with return stack, prioritised interrupt entry,
// stall and sticky stack-error flags. All state changes on the falling edge.
module pc_unit_stk
   import pc_unit_pkg::*;
#(
   parameter int            AW        = 16,
   parameter int            DEPTH     = 8,
   parameter int            NINT      = 4,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       stall,
   input  logic                       pc_inc,
   input  logic                       jmp,
   input  logic                       call,
   input  logic                       ret,
   input  logic                       reti,
   input  logic [AW-1:0]              target,
   input  logic                       int_en,
   input  logic [NINT-1:0]            int_req,
   input  logic [AW-1:0]              int_base,
   input  logic                       err_clr,
   output logic [AW-1:0]              pc,
   output logic [NINT-1:0]            int_ack,
   output logic                       in_isr,
   output logic [$clog2(DEPTH+1)-1:0] stk_level,
   output logic                       stk_ovf,
   output logic                       stk_unf
);

   cmd_e                cmd;
   logic [MAX_NINT-1:0] req_ext;
   int                  k;
   logic [AW-1:0]       pc_plus1;
   logic [AW-1:0]       seq_pc;
   logic [AW-1:0]       int_vec;
   logic [AW-1:0]       pc_nxt;
   logic                isr_nxt;
   logic                push;
   logic                pop;
   logic [AW-1:0]       push_data;
   logic [AW-1:0]       stk_top;
   logic                stk_full;
   logic                stk_empty;
   logic                ovf_set;
   logic                unf_set;
   logic                flag_clr;

   pc_ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_stack (
      .CLK      (CLK),
      .RST      (RST),
      .push     (push),
      .pop      (pop),
      .data_in  (push_data),
      .data_out (stk_top),
      .level    (stk_level),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   assign req_ext  = MAX_NINT'(int_req);
   assign k        = prio_index(req_ext, NINT);
   assign pc_plus1 = pc + AW'(1);
   assign int_vec  = int_base + AW'(k);
   assign seq_pc   = jmp ? target : (pc_inc ? pc_plus1 : pc);

   // Interrupt entry ranks below the stack commands, so a request arriving
   // with call/ret/reti simply waits for the next free cycle.
   always_comb begin
      cmd = HOLD;
      if (!stall) begin
         if (reti)                                cmd = RETI;
         else if (ret)                            cmd = RET;
         else if (call)                           cmd = CALL;
         else if (int_en && !in_isr && |int_req)  cmd = INTE;
         else if (jmp)                            cmd = JMP;
         else if (pc_inc)                         cmd = INC;
      end
   end

   always_comb begin
      pc_nxt    = pc;
      isr_nxt   = in_isr;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = pc_plus1;
      int_ack   = '0;
      case (cmd)
         INC: pc_nxt = pc_plus1;
         JMP: pc_nxt = target;
         CALL: begin
            push      = 1'b1;
            push_data = pc_plus1;
            pc_nxt    = target;
         end
         RET: begin
            pop = 1'b1;
            if (!stk_empty) pc_nxt = stk_top;
         end
         RETI: begin
            pop     = 1'b1;
            isr_nxt = 1'b0;
            if (!stk_empty) pc_nxt = stk_top;
         end
         INTE: begin
            push      = 1'b1;
            push_data = seq_pc;
            pc_nxt    = int_vec;
            isr_nxt   = 1'b1;
            int_ack   = NINT'(1) << k;
         end
         default: ;
      endcase
   end

   assign ovf_set  = push && stk_full;
   assign unf_set  = pop && stk_empty;
   // A stalled cycle freezes everything, including the clear request.
   assign flag_clr = err_clr && !stall;

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         pc      <= RESET_VEC;
         in_isr  <= 1'b0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         pc      <= pc_nxt;
         in_isr  <= isr_nxt;
         stk_ovf <= ovf_set || (stk_ovf && !flag_clr);
         stk_unf <= unf_set || (stk_unf && !flag_clr);
      end
   end

endmodule

// File: tb/tb_pc_unit_stk.sv
// Directed bench for pc_unit_stk: a queue-based reference model is checked
// every cycle, plus literal expectations along the directed sequence.
`timescale 1ns/1ps
module tb_pc_unit_stk;

   localparam int            AW    = 16;
   localparam int            DEPTH = 8;
   localparam int            NINT  = 4;
   localparam logic [AW-1:0] RV    = 16'h0100;

   logic            CLK;
   logic            RST;
   logic            stall, pc_inc, jmp, call, ret, reti, int_en, err_clr;
   logic [AW-1:0]   target, int_base;
   logic [NINT-1:0] int_req;
   logic [AW-1:0]   pc;
   logic [NINT-1:0] int_ack;
   logic            in_isr;
   logic [3:0]      stk_level;
   logic            stk_ovf, stk_unf;

   int errors = 0;
   int checks = 0;

   pc_unit_stk #(
      .AW        (AW),
      .DEPTH     (DEPTH),
      .NINT      (NINT),
      .RESET_VEC (RV)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .stall     (stall),
      .pc_inc    (pc_inc),
      .jmp       (jmp),
      .call      (call),
      .ret       (ret),
      .reti      (reti),
      .target    (target),
      .int_en    (int_en),
      .int_req   (int_req),
      .int_base  (int_base),
      .err_clr   (err_clr),
      .pc        (pc),
      .int_ack   (int_ack),
      .in_isr    (in_isr),
      .stk_level (stk_level),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: stack as a queue, PC as plain arithmetic.
   logic [AW-1:0] m_pc  = RV;
   logic [AW-1:0] m_stk [$];
   logic          m_isr = 1'b0;
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   initial begin
      logic [NINT-1:0] exp_ack;
      logic [AW-1:0]   resume;
      logic            new_ovf, new_unf;
      int              kk;
      forever begin
         @(posedge CLK);
         #3;
         if (RST) begin
            m_pc  = RV;
            m_stk.delete();
            m_isr = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         chk("model_pc", pc, m_pc);
         chk("model_level", stk_level, m_stk.size());
         chk("model_in_isr", in_isr, m_isr);
         chk("model_ovf", stk_ovf, m_ovf);
         chk("model_unf", stk_unf, m_unf);
         exp_ack = '0;
         if (!RST && !stall) begin
            new_ovf = 1'b0;
            new_unf = 1'b0;
            if (reti || ret) begin
               if (m_stk.size() == 0) new_unf = 1'b1;
               else m_pc = m_stk.pop_back();
               if (reti) m_isr = 1'b0;
            end else if (call) begin
               if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
               else new_ovf = 1'b1;
               m_pc = target;
            end else if (int_en && !m_isr && int_req != 0) begin
               kk = 0;
               for (int i = NINT - 1; i >= 0; i--) if (int_req[i]) kk = i;
               resume = jmp ? target : (pc_inc ? m_pc + 16'd1 : m_pc);
               if (m_stk.size() < DEPTH) m_stk.push_back(resume);
               else new_ovf = 1'b1;
               m_pc = int_base + 16'(kk);
               m_isr = 1'b1;
               exp_ack[kk] = 1'b1;
            end else if (jmp) begin
               m_pc = target;
            end else if (pc_inc) begin
               m_pc = m_pc + 16'd1;
            end
            m_ovf = new_ovf || (m_ovf && !err_clr);
            m_unf = new_unf || (m_unf && !err_clr);
         end
         chk("model_int_ack", int_ack, exp_ack);
      end
   end

   task automatic clr();
      stall = 0; pc_inc = 0; jmp = 0; call = 0; ret = 0; reti = 0;
      int_en = 0; err_clr = 0; int_req = '0; target = '0; int_base = '0;
   endtask

   // Advance to 1 ns after the next rising edge; the falling edge in between
   // has applied the vector that was set up.
   task automatic cyc();
      @(posedge CLK);
      #1;
      clr();
   endtask

   task automatic ack_chk(input string name, input logic [NINT-1:0] exp);
      #1;
      chk(name, int_ack, exp);
   endtask

   initial begin
      clr();
      RST = 1'b1;
      repeat (2) cyc();
      chk("rst_pc", pc, 16'h0100);
      chk("rst_level", stk_level, 0);
      chk("rst_isr", in_isr, 0);
      chk("rst_ack", int_ack, 0);
      chk("rst_flags", {stk_ovf, stk_unf}, 0);
      RST = 1'b0;

      // Sequential advance and silent wrap.
      for (int i = 0; i < 3; i++) begin
         pc_inc = 1; cyc();
      end
      chk("inc3_pc", pc, 16'h0103);
      jmp = 1; target = 16'hFFFF; cyc();
      chk("jmp_ffff", pc, 16'hFFFF);
      pc_inc = 1; cyc();
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_flags", {stk_ovf, stk_unf}, 0);

      // Call / return.
      jmp = 1; target = 16'h0010; cyc();
      call = 1; target = 16'h0200; cyc();
      chk("call_pc", pc, 16'h0200);
      chk("call_level", stk_level, 1);
      ret = 1; cyc();
      chk("ret_pc", pc, 16'h0011);
      chk("ret_level", stk_level, 0);

      // Interrupt entry with pc_inc absorbed, no nesting, reti, re-entry.
      jmp = 1; target = 16'h0020; cyc();
      int_en = 1; int_base = 16'h0F00; int_req = 4'b1010; pc_inc = 1;
      ack_chk("int1_ack", 4'b0010);
      cyc();
      chk("int1_pc", pc, 16'h0F01);
      chk("int1_isr", in_isr, 1);
      int_en = 1; int_base = 16'h0F00; int_req = 4'b0001;
      ack_chk("nest_ack", 4'b0000);
      cyc();
      chk("nest_pc", pc, 16'h0F01);
      int_en = 1; int_base = 16'h0F00; int_req = 4'b0001; reti = 1;
      ack_chk("reti_ack", 4'b0000);
      cyc();
      chk("reti_pc", pc, 16'h0021);
      chk("reti_isr", in_isr, 0);
      int_en = 1; int_base = 16'h0F00; int_req = 4'b0001;
      ack_chk("int0_ack", 4'b0001);
      cyc();
      chk("int0_pc", pc, 16'h0F00);
      reti = 1; cyc();
      chk("reti2_pc", pc, 16'h0021);

      // Overflow on the ninth nested call, then unwind and underflow.
      for (int i = 0; i < DEPTH + 1; i++) begin
         call = 1; target = 16'h1000 + 16'(i); cyc();
      end
      chk("ovf_level", stk_level, 8);
      chk("ovf_flag", stk_ovf, 1);
      chk("ovf_pc", pc, 16'h1008);
      for (int j = 0; j < DEPTH; j++) begin
         ret = 1; cyc();
         chk("unwind_pc", pc, (j < DEPTH - 1) ? 16'h1007 - 16'(j) : 16'h0022);
      end
      ret = 1; cyc();
      chk("unf_flag", stk_unf, 1);
      chk("unf_pc", pc, 16'h0022);
      chk("unf_level", stk_level, 0);
      ret = 1; err_clr = 1; cyc();
      chk("clr_vs_err", stk_unf, 1);
      err_clr = 1; cyc();
      chk("clr_flags", {stk_ovf, stk_unf}, 0);

      // Interrupt deferred by call, then taken with correct resume address.
      call = 1; target = 16'h0300; int_en = 1; int_base = 16'h0F00; int_req = 4'b0100;
      ack_chk("defer_ack", 4'b0000);
      cyc();
      chk("defer_pc", pc, 16'h0300);
      chk("defer_isr", in_isr, 0);
      int_en = 1; int_base = 16'h0F00; int_req = 4'b0100;
      ack_chk("late_ack", 4'b0100);
      cyc();
      chk("late_pc", pc, 16'h0F02);
      chk("late_level", stk_level, 2);
      reti = 1; cyc();
      chk("late_resume", pc, 16'h0300);
      ret = 1; cyc();
      chk("late_ret", pc, 16'h0023);
      stall = 1; jmp = 1; target = 16'h0555; int_en = 1; int_req = 4'b0001;
      ack_chk("stall_ack", 4'b0000);
      cyc();
      chk("stall_pc", pc, 16'h0023);
      chk("stall_isr", in_isr, 0);
      jmp = 1; target = 16'h0700; int_en = 1; int_base = 16'h0F00; int_req = 4'b0001;
      ack_chk("intjmp_ack", 4'b0001);
      cyc();
      chk("intjmp_pc", pc, 16'h0F00);
      reti = 1; cyc();
      chk("intjmp_resume", pc, 16'h0700);
      pc_inc = 1; int_en = 1; int_base = 16'hFFFF; int_req = 4'b0100;
      cyc();
      chk("vec_wrap_pc", pc, 16'h0001);
      reti = 1; cyc();
      chk("vec_wrap_resume", pc, 16'h0701);

      // Asynchronous reset mid-ISR with three entries stacked.
      ret = 1; cyc();
      call = 1; target = 16'h0400; cyc();
      call = 1; target = 16'h0410; cyc();
      int_en = 1; int_base = 16'h0F00; int_req = 4'b0001; cyc();
      chk("pre_rst_level", stk_level, 3);
      chk("pre_rst_isr", in_isr, 1);
      chk("pre_rst_unf", stk_unf, 1);
      RST = 1'b1;
      #1;
      chk("arst_pc", pc, 16'h0100);
      chk("arst_isr", in_isr, 0);
      chk("arst_level", stk_level, 0);
      chk("arst_flags", {stk_ovf, stk_unf}, 0);
      cyc();
      RST = 1'b0;
      pc_inc = 1; cyc();
      chk("post_rst_pc", pc, 16'h0101);
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
